instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Upstream neighbour of the instruction decoder in the MIPS CPU. Holds the PC and fetches each instruction from instruction memory over a req/ack handshake. Presents the instruction and PC+4 (the JAL link address) to the decoder, and computes the next PC from branch/jump controls and decoder/ALU results. A three-state FSM gates execution, so the rest of the datapath commits state only during the one-cycle oInstrValid strobe.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IMEM_ADDR_WIDTH, 14, word-address width of instruction memory.

Ports:
iCpuClock  in  1  CPU clock; all state updates on the rising edge.
iCpuReset  in  1  asynchronous, active-high reset.
oImemReq  out  1  fetch request to instruction memory.
oImemAddr  out  IMEM_ADDR_WIDTH  word address, PC[IMEM_ADDR_WIDTH+1:2].
iImemRdata  in  32  instruction word returned by memory.
iImemAck  in  1  read data valid this cycle.
iBranch  in  1  beq from control unit.
iNBranch  in  1  bne from control unit.
iZero  in  1  ALU zero flag.
iJmp  in  1  j instruction.
iJal  in  1  jal instruction.
iJr  in  1  jr instruction.
iSignExtendedImmediate  in  32  extended immediate from decoder.
iRegRs  in  32  R[rs] from decoder (jr target).
iHalt  in  1  stop after the current instruction.
oInstruction  out  32  registered instruction word.
oJalLinkAddress  out  32  PC+4.
oPc  out  32  current PC.
oInstrValid  out  1  execute strobe; register/memory writes are gated by it.

Behaviour:
- Reset (async, any state): PC=RESET_PC, state=FETCH, oInstruction=0 (nop), oInstrValid=0. oImemReq=0 while iCpuReset is high.
- FSM states: FETCH, EXEC, HALTED.
- FETCH: oImemReq=1 and oImemAddr stable. On iImemAck: oInstruction<=iImemRdata, go to EXEC. Without ack: stay, PC held. Ack in the same cycle as req is legal, giving 2 cycles per instruction minimum.
- EXEC: oImemReq=0 and oInstrValid=1 for exactly one cycle. Control inputs are sampled combinationally, and PC<=nextPC at the closing edge. Go to HALTED if iHalt, otherwise FETCH.
- HALTED: oImemReq=0 and oInstrValid=0. PC holds the post-halt nextPC. The only exit is reset.
- iImemAck outside FETCH is ignored.
- oJalLinkAddress = PC+4, combinational from the PC register.
- nextPC priority:
  - iJr: {iRegRs[31:2],2'b00}.
  - else iJal|iJmp: {PC4[31:28], oInstruction[25:0], 2'b00}.
  - else taken branch: PC4 + (iSignExtendedImmediate<<2). Taken = (iBranch&iZero)|(iNBranch&~iZero).
  - else PC4.
- All address arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- PC[1:0] is always 00.
- Control inputs are don't-care outside EXEC.
- Reset during EXEC: the strobe drops immediately and the PC update is lost.

Decomposition:
- Shared package holds:
  - FSM state encoding (FETCH=2'd0, EXEC=2'd1, HALTED=2'd2).
  - RESET_PC default.
  - The constant 4 used for the PC increment.
- One combinational sub-module, next_pc_logic: inputs PC, instruction[25:0], controls, immediate, iRegRs; outputs nextPC and PC4.
- The FSM and PC/instruction registers stay in instruction_fetch.

Test Plan:
- Sequential fetch, zero wait states:
  - Stimulus: reset, then ack in the same cycle as req; rdata=32'h2008_0005.
  - Response: oImemAddr=0; oInstruction=32'h2008_0005 with oInstrValid=1 in cycle 2; oJalLinkAddress=4; next oImemAddr=1.
- Branches at PC=0x10, imm=32'hFFFF_FFFF:
  - beq with iZero=1: next PC=0x10.
  - bne with iZero=1: next PC=0x14.
  - bne with iZero=0: next PC=0x10.
- jal at PC=0x3000_0000, instr=32'h0C00_0010:
  - oJalLinkAddress=0x3000_0004 during EXEC.
  - next PC=0x3000_0040.
- jr with iRegRs=0x0000_0123, iBranch=1, iZero=1:
  - next PC=0x0000_0120 (jr wins over the branch).
- Wait states:
  - ack delayed 3 cycles: oImemReq held high, oImemAddr constant, oInstrValid=0 throughout.
  - iCpuReset asserted mid-FETCH: oImemReq=0 and oPc=RESET_PC immediately, without waiting for an edge.
- Halt and wrap:
  - iHalt=1 in EXEC at PC=0x8: oPc=0xC, then oImemReq and oInstrValid stay 0 for 20 cycles.
  - Separately, sequential instruction at PC=32'hFFFF_FFFC: next PC=0.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared FSM encoding and PC constants for the fetch stage
package instruction_fetch_pkg;
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } state_e;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/instruction_fetch_next_pc_logic.sv
// next_pc_logic: combinational next-PC selection (jr > j/jal > taken branch > PC+4)
module next_pc_logic
  import instruction_fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [25:0] target_i,
  input  logic        branch_i,
  input  logic        nbranch_i,
  input  logic        zero_i,
  input  logic        jump_i,
  input  logic        jr_i,
  input  logic [29:0] imm_i,
  input  logic [29:0] rs_i,
  output logic [31:0] next_pc_o,
  output logic [31:0] pc4_o
);
  logic taken;
  assign pc4_o = pc_i + PC_INC;
  assign taken = (branch_i & zero_i) | (nbranch_i & ~zero_i);
  always_comb
    next_pc_o = jr_i   ? {rs_i, 2'b00} :
                jump_i ? {pc4_o[31:28], target_i, 2'b00} :
                taken  ? pc4_o + {imm_i, 2'b00} :
                         pc4_o;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, imem req/ack fetch FSM and one-cycle execute strobe
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int          IMEM_ADDR_WIDTH = 14
) (
  input  logic                       iCpuClock,
  input  logic                       iCpuReset,
  output logic                       oImemReq,
  output logic [IMEM_ADDR_WIDTH-1:0] oImemAddr,
  input  logic [31:0]                iImemRdata,
  input  logic                       iImemAck,
  input  logic                       iBranch,
  input  logic                       iNBranch,
  input  logic                       iZero,
  input  logic                       iJmp,
  input  logic                       iJal,
  input  logic                       iJr,
  input  logic [31:0]                iSignExtendedImmediate,
  input  logic [31:0]                iRegRs,
  input  logic                       iHalt,
  output logic [31:0]                oInstruction,
  output logic [31:0]                oJalLinkAddress,
  output logic [31:0]                oPc,
  output logic                       oInstrValid
);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, next_pc, pc4;

  next_pc_logic u_next_pc (
    .pc_i      (pc_q),
    .target_i  (instr_q[25:0]),
    .branch_i  (iBranch),
    .nbranch_i (iNBranch),
    .zero_i    (iZero),
    .jump_i    (iJmp | iJal),
    .jr_i      (iJr),
    .imm_i     (iSignExtendedImmediate[29:0]),
    .rs_i      (iRegRs[31:2]),
    .next_pc_o (next_pc),
    .pc4_o     (pc4)
  );

  always_comb begin
    state_d = state_q == FETCH ? (iImemAck ? EXEC : FETCH) :
              state_q == EXEC  ? (iHalt ? HALTED : FETCH) : HALTED;
    instr_d = (state_q == FETCH && iImemAck) ? iImemRdata : instr_q;
    pc_d    = state_q == EXEC ? next_pc : pc_q;
  end

  always_ff @(posedge iCpuClock or posedge iCpuReset)
    if (iCpuReset) begin
      state_q <= FETCH;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end

  // state is already FETCH while reset is held, so the request must be masked explicitly
  assign oImemReq        = state_q == FETCH && !iCpuReset;
  assign oImemAddr       = pc_q[IMEM_ADDR_WIDTH+1:2];
  assign oInstruction    = instr_q;
  assign oJalLinkAddress = pc4;
  assign oPc             = pc_q;
  assign oInstrValid     = state_q == EXEC;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized self-checking bench against a next-PC reference model
module tb_instruction_fetch;
  logic        clk = 0, rst = 1;
  logic        req, ack = 0, valid;
  logic [13:0] addr;
  logic [31:0] rdata = 0, instr, link, pc, imm = 0, rs = 0;
  logic        br = 0, nbr = 0, zero = 0, jmp = 0, jal = 0, jr = 0, halt = 0;
  int          tests = 0, fails = 0;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .iCpuClock(clk), .iCpuReset(rst), .oImemReq(req), .oImemAddr(addr),
    .iImemRdata(rdata), .iImemAck(ack), .iBranch(br), .iNBranch(nbr), .iZero(zero),
    .iJmp(jmp), .iJal(jal), .iJr(jr), .iSignExtendedImmediate(imm), .iRegRs(rs),
    .iHalt(halt), .oInstruction(instr), .oJalLinkAddress(link), .oPc(pc), .oInstrValid(valid)
  );

  function automatic logic [31:0] ref_next(input logic [31:0] p, w, input logic c_jr, c_jal, c_jmp,
                                           c_br, c_nbr, c_zero, input logic [31:0] c_imm, c_rs);
    logic [31:0] p4;
    p4 = p + 4;
    if (c_jr) return c_rs & ~32'd3;
    if (c_jal || c_jmp) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
    if ((c_br && c_zero) || (c_nbr && !c_zero)) return p4 + c_imm * 4;
    return p4;
  endfunction

  task automatic scramble_ctrl();
    {br, nbr, zero, jmp, jal, jr, halt} = 7'($urandom);
    imm = $urandom;
    rs  = $urandom;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    #1;
    tests++;
    if (req !== 0 || pc !== 0 || valid !== 0 || instr !== 0) begin
      fails++;
      $display("FAIL reset req=%b pc=%h valid=%b instr=%h required 0/0/0/0", req, pc, valid, instr);
    end
    @(negedge clk);
    rst = 0;
    m_pc = 0;
    #1;
  endtask

  task automatic do_instr(input logic [31:0] w, input int waits, input logic c_jr, c_jal, c_jmp,
                          c_br, c_nbr, c_zero, c_halt, input logic [31:0] c_imm, c_rs);
    logic [13:0] ea;
    ea = m_pc[15:2];
    for (int i = 0; i < waits; i++) begin
      ack = 0; rdata = $urandom; scramble_ctrl();
      #1;
      tests++;
      if (req !== 1 || addr !== ea || valid !== 0 || pc !== m_pc) begin
        fails++;
        $display("FAIL wait_state req=%b addr=%h valid=%b pc=%h required 1/%h/0/%h", req, addr, valid, pc, ea, m_pc);
      end
      @(negedge clk);
    end
    ack = 1; rdata = w; scramble_ctrl();
    #1;
    tests++;
    if (req !== 1 || addr !== ea || valid !== 0) begin
      fails++;
      $display("FAIL fetch req=%b addr=%h valid=%b required 1/%h/0", req, addr, valid, ea);
    end
    @(negedge clk);
    ack = 1'($urandom); rdata = $urandom;
    jr = c_jr; jal = c_jal; jmp = c_jmp; br = c_br; nbr = c_nbr; zero = c_zero; halt = c_halt;
    imm = c_imm; rs = c_rs;
    #1;
    tests++;
    if (valid !== 1 || req !== 0 || instr !== w || link !== m_pc + 4 || pc !== m_pc) begin
      fails++;
      $display("FAIL exec valid=%b req=%b instr=%h link=%h pc=%h required 1/0/%h/%h/%h",
               valid, req, instr, link, pc, w, m_pc + 32'd4, m_pc);
    end
    m_pc = ref_next(m_pc, w, c_jr, c_jal, c_jmp, c_br, c_nbr, c_zero, c_imm, c_rs);
    @(negedge clk);
    ack = 0; halt = 0;
    #1;
    tests++;
    if (pc !== m_pc || valid !== 0) begin
      fails++;
      $display("FAIL next_pc pc=%h valid=%b required %h/0", pc, valid, m_pc);
    end
  endtask

  task automatic goto_pc(input logic [31:0] t);
    do_instr(32'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0, t);
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_seq_fetch();
    do_instr(32'h2008_0005, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (addr !== 14'd1) begin
      fails++;
      $display("FAIL seq_addr addr=%h required 1", addr);
    end
  endtask

  task automatic test_branches();
    goto_pc(32'h10);
    do_instr($urandom, 0, 0, 0, 0, 1, 0, 1, 0, 32'hFFFF_FFFF, 0);
    goto_pc(32'h10);
    do_instr($urandom, 1, 0, 0, 0, 0, 1, 1, 0, 32'hFFFF_FFFF, 0);
    goto_pc(32'h10);
    do_instr($urandom, 0, 0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_jal();
    goto_pc(32'h3000_0000);
    do_instr(32'h0C00_0010, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_jr_priority();
    do_instr($urandom, 0, 1, 0, 0, 1, 0, 1, 0, 32'h5, 32'h0000_0123);
  endtask

  task automatic test_wait_states();
    do_instr($urandom, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    goto_pc(32'h400);
    ack = 0;
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    tests++;
    if (req !== 0 || pc !== 0) begin
      fails++;
      $display("FAIL reset_mid_fetch req=%b pc=%h required 0/0", req, pc);
    end
    @(negedge clk);
    rst = 0;
    m_pc = 0;
    #1;
  endtask

  task automatic test_reset_exec();
    goto_pc(32'h80);
    ack = 1; rdata = $urandom;
    @(negedge clk);
    ack = 0; jr = 1; rs = 32'h40; halt = 0;
    #1;
    rst = 1;
    #1;
    tests++;
    if (valid !== 0) begin
      fails++;
      $display("FAIL reset_exec_strobe valid=%b required 0", valid);
    end
    @(negedge clk);
    rst = 0;
    m_pc = 0;
    #1;
    tests++;
    if (pc !== 0) begin
      fails++;
      $display("FAIL reset_exec_pc pc=%h required 0", pc);
    end
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    do_instr($urandom, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      do_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 5) == 0, 1'($urandom), 1'($urandom), 1'($urandom), 0, $urandom, $urandom);
  endtask

  task automatic test_halt();
    goto_pc(32'h8);
    do_instr($urandom, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      ack = 1'($urandom); rdata = $urandom; scramble_ctrl();
      @(negedge clk);
      #1;
      tests++;
      if (req !== 0 || valid !== 0 || pc !== 32'hC) begin
        fails++;
        $display("FAIL halted req=%b valid=%b pc=%h required 0/0/0000000c", req, valid, pc);
      end
    end
    ack = 0; halt = 0;
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_branches();
    test_jal();
    test_jr_priority();
    test_wait_states();
    test_reset_exec();
    test_wrap();
    test_random();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
